match_interp: RTL and testbench

// Sub-pixel interpolation/disparity stage directly downstream of the phase match core.
// - Consumes each match result (x0, y-y0, y-y1, pixel pos, not_found, tlast).
// - Computes the fractional crossing x_sub = x0 + (y-y0)/(y1-y0) with a fully pipelined restoring divider.
// - Emits disparity = pos - x_sub as fixed point on an AXI-Stream master.
// - The match core has no backpressure input, so results are buffered in an output FIFO; on overflow they are dropped and flagged.

---
 rtl/match_interp_if.sv | 39 +++
 rtl/match_interp.sv | 188 ++++++++++++++++++
 tb/tb_match_interp.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/match_interp_if.sv
// Bundle of the match-core result inputs and the AXI-Stream/status outputs of match_interp.
// slave is the interpolator side; master is the upstream/downstream environment side.
interface match_interp_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                             vld_i;
  logic                             not_found_i;
  logic [DATA_WIDTH-1:0]            x0_i;
  logic [DATA_WIDTH-1:0]            y_sub_y0_i;
  logic [DATA_WIDTH-1:0]            y_sub_y1_i;
  logic [DATA_WIDTH-1:0]            pos_i;
  logic                             tlast_i;

  logic                             m_axis_tvalid;
  logic                             m_axis_tready;
  logic [2*DATA_WIDTH+FRAC_BITS-1:0] m_axis_tdata;
  logic                             m_axis_tuser;
  logic                             m_axis_tlast;

  logic                             overflow_o;
  logic [15:0]                      drop_cnt_o;
  logic [$clog2(FIFO_DEPTH):0]      fifo_level_o;

  modport slave (
    input  vld_i, not_found_i, x0_i, y_sub_y0_i, y_sub_y1_i, pos_i, tlast_i,
    input  m_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
    output overflow_o, drop_cnt_o, fifo_level_o
  );

  modport master (
    output vld_i, not_found_i, x0_i, y_sub_y0_i, y_sub_y1_i, pos_i, tlast_i,
    output m_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
    input  overflow_o, drop_cnt_o, fifo_level_o
  );
endinterface

// File: rtl/match_interp.sv
// Sub-pixel crossing interpolation: x_sub = x0 + (y-y0)/(y1-y0) via a pipelined restoring
// divider, disparity = pos - x_sub, buffered in an output FIFO that drops on overflow.
module match_interp #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  match_interp_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int FB = FRAC_BITS;
  localparam int TW = 2*DW+FB;
  localparam int EW = TW+2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = DW+2;
  localparam logic [AW:0] LVL_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  // Operands and clamp decision; the divider only ever sees 0 < num < den.
  logic signed [DW:0] w_num;
  logic signed [DW:0] w_den;
  logic               w_clZero;
  logic               w_clMax;

  always_comb begin
    w_num    = {bus.y_sub_y0_i[DW-1], bus.y_sub_y0_i};
    w_den    = w_num - {bus.y_sub_y1_i[DW-1], bus.y_sub_y1_i};
    w_clZero = w_den[DW] || (w_den == '0) || w_num[DW] || (w_num == '0);
    w_clMax  = !w_clZero && (w_num >= w_den);
  end

  logic          r_vld    [0:FB];
  logic [RW-1:0] r_rem    [0:FB-1];
  logic [DW:0]   r_den    [0:FB-1];
  logic [FB-1:0] r_q      [0:FB];
  logic [DW-1:0] r_x0     [0:FB];
  logic [DW-1:0] r_pos    [0:FB];
  logic          r_nf     [0:FB];
  logic          r_last   [0:FB];
  logic          r_clZero [0:FB];
  logic          r_clMax  [0:FB];

  logic [RW-1:0] w_shift [1:FB];
  logic [RW-1:0] w_diff  [1:FB];

  always_comb begin
    for (int k = 1; k <= FB; k++) begin
      w_shift[k] = {r_rem[k-1][RW-2:0], 1'b0};
      w_diff[k]  = w_shift[k] - {1'b0, r_den[k-1]};
    end
  end

  // Only the valid chain is reset; data follows it freely and is ignored when not valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= FB; k++) begin
        r_vld[k] <= 1'b0;
      end
    end else begin
      r_vld[0] <= bus.vld_i;
      for (int k = 1; k <= FB; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_rem[0]    <= {w_num[DW], w_num};
    r_den[0]    <= w_den;
    r_q[0]      <= '0;
    r_x0[0]     <= bus.x0_i;
    r_pos[0]    <= bus.pos_i;
    r_nf[0]     <= bus.not_found_i;
    r_last[0]   <= bus.tlast_i;
    r_clZero[0] <= w_clZero;
    r_clMax[0]  <= w_clMax;
    for (int k = 1; k < FB; k++) begin
      r_rem[k] <= w_diff[k][RW-1] ? w_shift[k] : w_diff[k];
      r_den[k] <= r_den[k-1];
    end
    for (int k = 1; k <= FB; k++) begin
      r_q[k]      <= {r_q[k-1][FB-2:0], ~w_diff[k][RW-1]};
      r_x0[k]     <= r_x0[k-1];
      r_pos[k]    <= r_pos[k-1];
      r_nf[k]     <= r_nf[k-1];
      r_last[k]   <= r_last[k-1];
      r_clZero[k] <= r_clZero[k-1];
      r_clMax[k]  <= r_clMax[k-1];
    end
  end

  logic [FB-1:0]    w_qFinal;
  logic [DW+FB-1:0] w_xSub;
  logic [DW+FB-1:0] w_disp;

  always_comb begin
    w_qFinal = r_q[FB];
    if (r_clZero[FB]) begin
      w_qFinal = '0;
    end else if (r_clMax[FB]) begin
      w_qFinal = '1;
    end
    w_xSub = {r_x0[FB], {FB{1'b0}}} + {{DW{1'b0}}, w_qFinal};
    w_disp = {r_pos[FB], {FB{1'b0}}} - w_xSub;
    if (r_nf[FB]) begin
      w_disp = '0;
    end
  end

  logic          r_fVld;
  logic [EW-1:0] r_fEntry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fVld <= 1'b0;
    end else begin
      r_fVld <= r_vld[FB];
    end
  end

  always_ff @(posedge clk) begin
    r_fEntry <= {r_pos[FB], w_disp, r_nf[FB], r_last[FB]};
  end

  // Output FIFO; pointers carry one wrap bit so full and empty are distinguishable.
  logic [EW-1:0] r_mem [0:FIFO_DEPTH-1];
  logic [AW:0]   r_wPtr;
  logic [AW:0]   r_rPtr;
  logic          r_overflow;
  logic [15:0]   r_dropCnt;
  logic [AW:0]   w_level;
  logic          w_empty;
  logic          w_full;
  logic          w_rd;
  logic          w_wr;
  logic          w_drop;
  logic [EW-1:0] w_head;

  always_comb begin
    w_level = r_wPtr - r_rPtr;
    w_empty = (r_wPtr == r_rPtr);
    w_full  = (w_level == LVL_FULL);
    w_rd    = !w_empty && bus.m_axis_tready;
    w_wr    = r_fVld && (!w_full || w_rd);
    w_drop  = r_fVld && w_full && !w_rd;
    w_head  = r_mem[r_rPtr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wPtr[AW-1:0]] <= r_fEntry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wPtr     <= '0;
      r_rPtr     <= '0;
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else begin
      if (w_wr) begin
        r_wPtr <= r_wPtr + PTR_ONE;
      end
      if (w_rd) begin
        r_rPtr <= r_rPtr + PTR_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropCnt != 16'hFFFF) begin
          r_dropCnt <= r_dropCnt + 16'd1;
        end
      end
    end
  end

  // Head entry is gated so the bus reads all-zero whenever nothing is valid.
  assign bus.m_axis_tvalid = !w_empty;
  assign bus.m_axis_tdata  = w_empty ? '0 : w_head[EW-1:2];
  assign bus.m_axis_tuser  = !w_empty && w_head[1];
  assign bus.m_axis_tlast  = !w_empty && w_head[0];
  assign bus.overflow_o    = r_overflow;
  assign bus.drop_cnt_o    = r_dropCnt;
  assign bus.fifo_level_o  = w_level;

endmodule

// File: tb/tb_match_interp.sv
// Self-checking bench for match_interp: hand-computed vectors, random stream against a
// floor-division model, FIFO overflow/backpressure and mid-flight reset.
module tb_match_interp;
  logic clk;
  logic rst_n;

  match_interp_if #(.DATA_WIDTH(16), .FRAC_BITS(8), .FIFO_DEPTH(16)) bus ();

  match_interp #(.DATA_WIDTH(16), .FRAC_BITS(8), .FIFO_DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x0;
    logic [15:0] y0d;
    logic [15:0] y1d;
    logic [15:0] pos;
    logic        nf;
    logic        last;
    logic [39:0] expData;
    logic        expUser;
    logic        expLast;
  } vec_t;

  vec_t        vecs [9];
  logic [41:0] expQ [$];
  logic [41:0] expHead;
  int          checks = 0;
  int          passes = 0;
  int          beatCount = 0;
  int          beatStart;
  int          cycles;
  bit          monOn = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer floor division with the clamp rules, then fixed-point subtract.
  function automatic logic [41:0] model(input logic [15:0] x0, input logic [15:0] y0d,
                                        input logic [15:0] y1d, input logic [15:0] pos,
                                        input logic nf, input logic last);
    int          num;
    int          den;
    int          q;
    int          disp;
    logic [23:0] d;
    num = $signed(y0d);
    den = $signed(y0d) - $signed(y1d);
    if (den <= 0 || num <= 0) q = 0;
    else if (num >= den) q = 255;
    else q = (num * 256) / den;
    disp = $signed(pos) * 256 - ($signed(x0) * 256 + q);
    d = disp[23:0];
    if (nf) d = '0;
    return {pos, d, nf, last};
  endfunction

  task automatic applyStimulus(input vec_t v, input bit expectOut);
    bus.vld_i       = 1'b1;
    bus.x0_i        = v.x0;
    bus.y_sub_y0_i  = v.y0d;
    bus.y_sub_y1_i  = v.y1d;
    bus.pos_i       = v.pos;
    bus.not_found_i = v.nf;
    bus.tlast_i     = v.last;
    if (expectOut) expQ.push_back({v.expData, v.expUser, v.expLast});
    @(posedge clk); #1;
    bus.vld_i = 1'b0;
  endtask

  function automatic vec_t randVec();
    vec_t v;
    logic [41:0] m;
    v.x0   = 16'($urandom);
    v.pos  = 16'($urandom);
    v.nf   = ($urandom_range(0, 7) == 0);
    v.last = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 3) == 0) begin
      v.y0d = 16'($urandom);
      v.y1d = 16'($urandom);
    end else begin
      v.y0d = 16'($urandom_range(0, 400)) - 16'd100;
      v.y1d = 16'($urandom_range(0, 400)) - 16'd300;
    end
    m = model(v.x0, v.y0d, v.y1d, v.pos, v.nf, v.last);
    v.expData = m[41:2];
    v.expUser = m[1];
    v.expLast = m[0];
    return v;
  endfunction

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while ((expQ.size() != 0 || bus.m_axis_tvalid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, expQ.size(), 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Tvalid"}, bus.m_axis_tvalid, 0);
    checkOutput({tag, "Tdata"}, bus.m_axis_tdata, 0);
    checkOutput({tag, "Tuser"}, bus.m_axis_tuser, 0);
    checkOutput({tag, "Tlast"}, bus.m_axis_tlast, 0);
    checkOutput({tag, "Overflow"}, bus.overflow_o, 0);
    checkOutput({tag, "DropCnt"}, bus.drop_cnt_o, 0);
    checkOutput({tag, "Level"}, bus.fifo_level_o, 0);
  endtask

  // Beats are sampled mid-cycle; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (monOn && rst_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
      beatCount++;
      if (expQ.size() == 0) begin
        checkOutput($sformatf("unexpectedBeat%0d", beatCount),
                    {bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}, 0);
      end else begin
        expHead = expQ.pop_front();
        checkOutput($sformatf("beat%0d", beatCount),
                    {bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}, expHead);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{16'd100, 16'd1, 16'hFFFD, 16'd150, 1'b0, 1'b0, {16'd150, 24'h0031C0}, 1'b0, 1'b0};
    vecs[1] = '{16'd10, 16'd5, 16'd0, 16'd20, 1'b0, 1'b0, {16'd20, 24'h000901}, 1'b0, 1'b0};
    vecs[2] = '{16'd10, 16'd0, 16'd0, 16'd20, 1'b0, 1'b0, {16'd20, 24'h000A00}, 1'b0, 1'b0};
    vecs[3] = '{16'd7, 16'hFFFE, 16'hFFFC, 16'd5, 1'b0, 1'b0, {16'd5, 24'hFFFE00}, 1'b0, 1'b0};
    vecs[4] = '{16'd33, 16'd3, 16'hFFFF, 16'd77, 1'b1, 1'b1, {16'd77, 24'h000000}, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFB, 16'd3, 16'hFFFB, 16'hFFFE, 1'b0, 1'b0, {16'hFFFE, 24'h0002A0}, 1'b0, 1'b0};
    vecs[6] = '{16'd0, 16'd1, 16'hFFFE, 16'd0, 1'b0, 1'b1, {16'd0, 24'hFFFFAB}, 1'b0, 1'b1};
    vecs[7] = '{16'd1, 16'hFFFD, 16'hFFFF, 16'd2, 1'b0, 1'b0, {16'd2, 24'h000100}, 1'b0, 1'b0};
    vecs[8] = '{16'd0, 16'd4, 16'hFFFF, 16'd1, 1'b0, 1'b0, {16'd1, 24'h000034}, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.vld_i = 1'b0;
    bus.not_found_i = 1'b0;
    bus.x0_i = '0;
    bus.y_sub_y0_i = '0;
    bus.y_sub_y1_i = '0;
    bus.pos_i = '0;
    bus.tlast_i = 1'b0;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkResetState("rst");

    $display("[TB] latency and hand-computed vectors");
    monOn = 1'b1;
    applyStimulus(vecs[0], 1'b1);
    cycles = 1;
    while (!bus.m_axis_tvalid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("latency", cycles, 11);
    waitDrain("drainFirst", 50);
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], 1'b1);
    waitDrain("drainTable", 100);

    $display("[TB] random back-to-back stream");
    beatStart = beatCount;
    for (int i = 0; i < 64; i++) begin
      v = randVec();
      applyStimulus(v, 1'b1);
    end
    waitDrain("drainRandom", 200);
    checkOutput("randomBeats", beatCount - beatStart, 64);
    checkOutput("randomNoDrops", bus.drop_cnt_o, 0);
    checkOutput("randomNoOverflow", bus.overflow_o, 0);

    $display("[TB] overflow under backpressure");
    bus.m_axis_tready = 1'b0;
    beatStart = beatCount;
    for (int i = 0; i < 18; i++) begin
      v = randVec();
      applyStimulus(v, i < 16);
    end
    repeat (12) begin
      @(posedge clk); #1;
    end
    checkOutput("fullLevel", bus.fifo_level_o, 16);
    checkOutput("fullOverflow", bus.overflow_o, 1);
    checkOutput("fullDropCnt", bus.drop_cnt_o, 2);
    checkOutput("stallTvalid", bus.m_axis_tvalid, 1);
    checkOutput("stallHead", {bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}, expQ[0]);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("stallHeadHeld", {bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}, expQ[0]);
    bus.m_axis_tready = 1'b1;
    waitDrain("drainOverflow", 100);
    checkOutput("overflowBeats", beatCount - beatStart, 16);
    checkOutput("overflowSticky", bus.overflow_o, 1);

    $display("[TB] reset with results buffered and in flight");
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = randVec();
      applyStimulus(v, 1'b1);
    end
    repeat (12) begin
      @(posedge clk); #1;
    end
    checkOutput("preResetLevel", bus.fifo_level_o, 3);
    for (int i = 0; i < 5; i++) begin
      v = randVec();
      applyStimulus(v, 1'b1);
    end
    rst_n = 1'b0;
    expQ.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkResetState("midRst");
    bus.m_axis_tready = 1'b1;
    beatStart = beatCount;
    repeat (20) begin
      @(posedge clk); #1;
    end
    checkOutput("staleBeats", beatCount - beatStart, 0);
    checkOutput("postResetLevel", bus.fifo_level_o, 0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
